// File: rtl/quadrature_decoder.sv
// quadrature_decoder
// Turns the asynchronous encoder phases A/B into a signed position count,
// a direction flag, a windowed speed measurement and a sticky error flag.
// The phases are double-flop synchronized and must hold steady for FILTER
// cycles before the decoder accepts them.

module quadrature_decoder #(
    parameter int POS_BITS      = 32,
    parameter int SPEED_BITS    = 16,
    parameter int FILTER        = 3,
    parameter int SAMPLE_CYCLES = 50000
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  A,
    input  logic                  B,
    input  logic                  CLEAR,
    input  logic                  ERROR_CLR,
    output logic [POS_BITS-1:0]   POSITION,
    output logic                  DIR,
    output logic [SPEED_BITS-1:0] SPEED,
    output logic                  SPEED_VALID,
    output logic                  ERROR
);

    localparam int CNT_W = $clog2(FILTER + 1);
    localparam int WIN_W = $clog2(SAMPLE_CYCLES);

    localparam logic [CNT_W-1:0]    FILTER_C = CNT_W'(FILTER);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);
    localparam logic [WIN_W-1:0]    WIN_ONE  = WIN_W'(1'b1);
    localparam logic [POS_BITS-1:0] POS_ONE  = POS_BITS'(1'b1);

    localparam logic signed [SPEED_BITS-1:0] SPD_ONE = SPEED_BITS'(1'b1);
    localparam logic signed [SPEED_BITS-1:0] SPD_MAX = {1'b0, {(SPEED_BITS-1){1'b1}}};
    localparam logic signed [SPEED_BITS-1:0] SPD_MIN = -SPD_MAX;

    localparam logic [1:0] STEP_NONE = 2'b00;
    localparam logic [1:0] STEP_FWD  = 2'b01;
    localparam logic [1:0] STEP_REV  = 2'b10;
    localparam logic [1:0] STEP_BAD  = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Classify a transition between two phase values {B,A}.
    // Forward order is 01 -> 11 -> 10 -> 00 -> 01.
    function automatic logic [1:0] classify_step(input logic [1:0] old_p, input logic [1:0] new_p);
        logic [1:0] kind;
        case ({old_p, new_p})
            4'b01_11, 4'b11_10, 4'b10_00, 4'b00_01: kind = STEP_FWD;
            4'b11_01, 4'b10_11, 4'b00_10, 4'b01_00: kind = STEP_REV;
            4'b01_10, 4'b10_01, 4'b00_11, 4'b11_00: kind = STEP_BAD;
            default:                                kind = STEP_NONE;
        endcase
        return kind;
    endfunction

    logic [1:0]                   sync1_r;
    logic [1:0]                   sync2_r;
    logic [1:0]                   cand_r;
    logic [CNT_W-1:0]             cnt_r;
    logic [1:0]                   acc_r;
    state_t                       state_r;
    logic [WIN_W-1:0]             win_r;
    logic signed [SPEED_BITS-1:0] spd_acc_r;

    logic [CNT_W-1:0]             cnt_inc_s;
    logic [CNT_W-1:0]             cnt_next_s;
    logic [1:0]                   cand_next_s;
    logic                         accept_s;
    logic [1:0]                   accept_val_s;
    logic [1:0]                   step_kind_s;
    logic                         step_fwd_s;
    logic                         step_rev_s;
    logic                         step_bad_s;
    logic                         win_last_s;
    logic signed [SPEED_BITS-1:0] spd_next_s;

    // Two-flop synchronizer for the asynchronous encoder phases.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {B, A};
            sync2_r <= sync1_r;
        end
    end

    // Stability filter: a new value is accepted once it has held for FILTER cycles.
    always_comb begin
        cnt_inc_s    = cnt_r + CNT_ONE;
        cnt_next_s   = cnt_r;
        cand_next_s  = cand_r;
        accept_s     = 1'b0;
        accept_val_s = cand_r;
        if (sync2_r == acc_r) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (sync2_r == cand_r) begin
            if (cnt_inc_s >= FILTER_C) begin
                accept_s   = 1'b1;
                cnt_next_s = {CNT_W{1'b0}};
            end else begin
                cnt_next_s = cnt_inc_s;
            end
        end else begin
            cand_next_s  = sync2_r;
            accept_val_s = sync2_r;
            if (FILTER_C == CNT_ONE) begin
                accept_s   = 1'b1;
                cnt_next_s = {CNT_W{1'b0}};
            end else begin
                cnt_next_s = CNT_ONE;
            end
        end
    end

    // Filter state registers; acc holds the last accepted phase value.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cand_r <= 2'b00;
            cnt_r  <= {CNT_W{1'b0}};
            acc_r  <= 2'b00;
        end else begin
            cand_r <= cand_next_s;
            cnt_r  <= cnt_next_s;
            if (accept_s) begin
                acc_r <= accept_val_s;
            end
        end
    end

    // Decode an accepted value against the previous one; INIT only loads.
    always_comb begin
        step_kind_s = STEP_NONE;
        if (accept_s && (state_r == ST_TRACK)) begin
            step_kind_s = classify_step(acc_r, accept_val_s);
        end else begin
            step_kind_s = STEP_NONE;
        end
    end

    assign step_fwd_s = (step_kind_s == STEP_FWD);
    assign step_rev_s = (step_kind_s == STEP_REV);
    assign step_bad_s = (step_kind_s == STEP_BAD);

    // Decoder FSM with the registered position, direction and error outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r  <= ST_INIT;
            POSITION <= {POS_BITS{1'b0}};
            DIR      <= 1'b0;
            ERROR    <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (accept_s) begin
                        state_r <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    state_r <= ST_TRACK;
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase

            // CLEAR overrides a step decoded on the same edge.
            if (CLEAR) begin
                POSITION <= {POS_BITS{1'b0}};
            end else if (step_fwd_s) begin
                POSITION <= POSITION + POS_ONE;
            end else if (step_rev_s) begin
                POSITION <= POSITION - POS_ONE;
            end

            if (step_fwd_s) begin
                DIR <= 1'b1;
            end else if (step_rev_s) begin
                DIR <= 1'b0;
            end

            // A new illegal transition wins over ERROR_CLR.
            if (step_bad_s) begin
                ERROR <= 1'b1;
            end else if (ERROR_CLR) begin
                ERROR <= 1'b0;
            end
        end
    end

    // Saturating update of the per-window step accumulator.
    always_comb begin
        win_last_s = (win_r == WIN_LAST);
        spd_next_s = spd_acc_r;
        if (step_fwd_s) begin
            if (spd_acc_r == SPD_MAX) begin
                spd_next_s = spd_acc_r;
            end else begin
                spd_next_s = spd_acc_r + SPD_ONE;
            end
        end else if (step_rev_s) begin
            if (spd_acc_r == SPD_MIN) begin
                spd_next_s = spd_acc_r;
            end else begin
                spd_next_s = spd_acc_r - SPD_ONE;
            end
        end else begin
            spd_next_s = spd_acc_r;
        end
    end

    // Free-running window; publishes the accumulator on the terminal count.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            win_r       <= {WIN_W{1'b0}};
            spd_acc_r   <= {SPEED_BITS{1'b0}};
            SPEED       <= {SPEED_BITS{1'b0}};
            SPEED_VALID <= 1'b0;
        end else if (win_last_s) begin
            win_r       <= {WIN_W{1'b0}};
            spd_acc_r   <= {SPEED_BITS{1'b0}};
            SPEED       <= spd_next_s;
            SPEED_VALID <= 1'b1;
        end else begin
            win_r       <= win_r + WIN_ONE;
            spd_acc_r   <= spd_next_s;
            SPEED_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Testbench for quadrature_decoder: hand-computed vector table, directed
// corner sequences, and randomized stimulus against a behavioural model.

module tb_quadrature_decoder;

    localparam int FILT = 3;
    localparam int SC   = 100;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        A;
    logic        B;
    logic        CLEAR;
    logic        ERROR_CLR;
    logic [7:0]  pos_a;
    logic [7:0]  pos_b;
    logic        dir_a;
    logic        dir_b;
    logic [15:0] spd_a;
    logic [3:0]  spd_b;
    logic        sv_a;
    logic        sv_b;
    logic        err_a;
    logic        err_b;

    int n_cmp = 0;
    int n_bad = 0;

    quadrature_decoder #(
        .POS_BITS(8), .SPEED_BITS(16), .FILTER(FILT), .SAMPLE_CYCLES(SC)
    ) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .A(A), .B(B), .CLEAR(CLEAR), .ERROR_CLR(ERROR_CLR),
        .POSITION(pos_a), .DIR(dir_a), .SPEED(spd_a), .SPEED_VALID(sv_a), .ERROR(err_a)
    );

    quadrature_decoder #(
        .POS_BITS(8), .SPEED_BITS(4), .FILTER(FILT), .SAMPLE_CYCLES(SC)
    ) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .A(A), .B(B), .CLEAR(CLEAR), .ERROR_CLR(ERROR_CLR),
        .POSITION(pos_b), .DIR(dir_b), .SPEED(spd_b), .SPEED_VALID(sv_b), .ERROR(err_b)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // ---------------- behavioural reference model ----------------
    bit         m_live = 1'b0;
    int         m_pos, m_cyc, m_sa16, m_sa4, m_sp16, m_sp4;
    bit         m_dir, m_err, m_init, m_sv;
    logic [1:0] m_acc;
    logic [1:0] p_hist[$];

    function automatic int ph_idx(input logic [1:0] p);
        case (p)
            2'b01:   return 0;
            2'b11:   return 1;
            2'b10:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int clamp(input int v, input int lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    always @(posedge CLOCK) begin : model_b
        int  dlt;
        int  d;
        bit  ill;
        bit  same;
        if (RESET) begin
            m_live = 1'b1; m_pos = 0; m_dir = 1'b0; m_err = 1'b0; m_init = 1'b1;
            m_acc = 2'b00; m_cyc = 0; m_sa16 = 0; m_sa4 = 0; m_sp16 = 0; m_sp4 = 0; m_sv = 1'b0;
            p_hist = {};
            for (int i = 0; i < FILT + 1; i++) p_hist.push_back(2'b00);
        end else if (m_live) begin
            dlt = 0; ill = 1'b0; same = 1'b1;
            // p_hist[0..FILT-1] are the synchronized values seen over the last FILT edges
            for (int i = 1; i < FILT; i++) if (p_hist[i] != p_hist[0]) same = 1'b0;
            if (same && (p_hist[0] != m_acc)) begin
                if (m_init) begin
                    m_init = 1'b0;
                end else begin
                    d = (ph_idx(p_hist[0]) - ph_idx(m_acc) + 4) % 4;
                    if (d == 1) dlt = 1;
                    else if (d == 3) dlt = -1;
                    else ill = 1'b1;
                end
                m_acc = p_hist[0];
            end
            p_hist.push_back({B, A});
            void'(p_hist.pop_front());
            if (dlt == 1) m_dir = 1'b1;
            else if (dlt == -1) m_dir = 1'b0;
            m_pos = CLEAR ? 0 : (m_pos + dlt + 256) % 256;
            if (ill) m_err = 1'b1;
            else if (ERROR_CLR) m_err = 1'b0;
            m_sa16 = clamp(m_sa16 + dlt, 32767);
            m_sa4  = clamp(m_sa4 + dlt, 7);
            if (m_cyc % SC == SC - 1) begin
                m_sp16 = m_sa16; m_sp4 = m_sa4; m_sa16 = 0; m_sa4 = 0; m_sv = 1'b1;
            end else begin
                m_sv = 1'b0;
            end
            m_cyc++;
        end
    end

    typedef struct {
        int          edge_i;
        logic [15:0] a;
        logic [3:0]  b;
    } pulse_t;
    pulse_t pulse_q[$];

    // Every-cycle comparison of both DUTs against the model, plus pulse log.
    always @(negedge CLOCK) begin
        pulse_t pr;
        if (m_live) begin
            check("model",
                  64'({pos_a, pos_b, dir_a, dir_b, err_a, err_b, spd_a, spd_b, sv_a, sv_b}),
                  64'({8'(m_pos), 8'(m_pos), m_dir, m_dir, m_err, m_err,
                       16'(m_sp16), 4'(m_sp4), m_sv, m_sv}));
            if (sv_a === 1'b1) begin
                pr.edge_i = m_cyc - 1; pr.a = spd_a; pr.b = spd_b;
                pulse_q.push_back(pr);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] p;
        logic       clr;
        logic       eclr;
        int         hold;
        logic [7:0] pos;
        logic       dir;
        logic       err;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input logic [1:0] p, input logic clr, input logic eclr, input int hold,
                           input logic [7:0] pos, input logic dir, input logic err);
        vec_t v;
        v.p = p; v.clr = clr; v.eclr = eclr; v.hold = hold; v.pos = pos; v.dir = dir; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic check_pde(input string name, input logic [7:0] pos, input logic dir, input logic err);
        check(name, 64'({pos_a, pos_b, dir_a, err_a}), 64'({pos, pos, dir, err}));
    endtask

    logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int cur_i;

    task automatic step(input bit fwd, input int period);
        cur_i = fwd ? (cur_i + 1) % 4 : (cur_i + 3) % 4;
        {B, A} = fwd_seq[cur_i];
        tick(period);
    endtask

    int          exp_edge [6] = '{99, 199, 299, 399, 499, 599};
    logic [15:0] exp_a    [6] = '{16'd19, 16'd20, 16'd20, 16'd10, 16'd10, 16'hFFEC};
    logic [3:0]  exp_b    [6] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'h9};

    initial begin
        RESET = 1'b1; {B, A} = 2'b10; CLEAR = 1'b0; ERROR_CLR = 1'b0;
        tick(3);
        check("reset state", 64'({pos_a, pos_b, dir_a, dir_b, err_a, err_b, spd_a, spd_b, sv_a, sv_b}), 64'd0);
        RESET = 1'b0;

        // {phase, clear, error_clr, hold, position, dir, error}
        add_vec(2'b10, 1'b0, 1'b0, 10, 8'd0,   1'b0, 1'b0); // first value only loads
        add_vec(2'b00, 1'b0, 1'b0, 10, 8'd1,   1'b1, 1'b0);
        add_vec(2'b00, 1'b1, 1'b0, 2,  8'd0,   1'b1, 1'b0); // clear keeps DIR
        add_vec(2'b01, 1'b0, 1'b0, 10, 8'd1,   1'b1, 1'b0);
        add_vec(2'b11, 1'b0, 1'b0, 10, 8'd2,   1'b1, 1'b0);
        add_vec(2'b10, 1'b0, 1'b0, 10, 8'd3,   1'b1, 1'b0);
        add_vec(2'b00, 1'b0, 1'b0, 10, 8'd4,   1'b1, 1'b0);
        add_vec(2'b01, 1'b0, 1'b0, 10, 8'd5,   1'b1, 1'b0);
        add_vec(2'b11, 1'b0, 1'b0, 10, 8'd6,   1'b1, 1'b0);
        add_vec(2'b10, 1'b0, 1'b0, 10, 8'd7,   1'b1, 1'b0);
        add_vec(2'b00, 1'b0, 1'b0, 10, 8'd8,   1'b1, 1'b0);
        add_vec(2'b10, 1'b0, 1'b0, 10, 8'd7,   1'b0, 1'b0);
        add_vec(2'b11, 1'b0, 1'b0, 10, 8'd6,   1'b0, 1'b0);
        add_vec(2'b01, 1'b0, 1'b0, 10, 8'd5,   1'b0, 1'b0);
        add_vec(2'b10, 1'b0, 1'b0, 10, 8'd5,   1'b0, 1'b1); // illegal 01->10
        add_vec(2'b00, 1'b0, 1'b0, 10, 8'd6,   1'b1, 1'b1); // legal step after it
        add_vec(2'b00, 1'b0, 1'b1, 3,  8'd6,   1'b1, 1'b0); // ERROR_CLR
        add_vec(2'b01, 1'b0, 1'b0, 2,  8'd6,   1'b1, 1'b0); // 2-cycle glitch
        add_vec(2'b00, 1'b0, 1'b0, 10, 8'd6,   1'b1, 1'b0);
        add_vec(2'b01, 1'b0, 1'b0, 10, 8'd7,   1'b1, 1'b0);
        add_vec(2'b01, 1'b1, 1'b0, 2,  8'd0,   1'b1, 1'b0);
        add_vec(2'b00, 1'b0, 1'b0, 10, 8'd255, 1'b0, 1'b0); // wrap below zero
        add_vec(2'b01, 1'b0, 1'b0, 10, 8'd0,   1'b1, 1'b0); // wrap above 255

        for (int i = 0; i < tbl.size(); i++) begin
            {B, A} = tbl[i].p; CLEAR = tbl[i].clr; ERROR_CLR = tbl[i].eclr;
            tick(tbl[i].hold);
            CLEAR = 1'b0; ERROR_CLR = 1'b0;
            check_pde($sformatf("vec%0d", i), tbl[i].pos, tbl[i].dir, tbl[i].err);
        end

        // exactly FILTER cycles of a new value is accepted, then it returns
        {B, A} = 2'b11; tick(3);
        {B, A} = 2'b01; tick(2);
        check_pde("hold exactly FILTER", 8'd1, 1'b1, 1'b0);
        tick(8);
        check_pde("return after short hold", 8'd0, 1'b0, 1'b0);

        // CLEAR on the same edge as a step
        {B, A} = 2'b11; tick(10);
        check_pde("step before clear", 8'd1, 1'b1, 1'b0);
        {B, A} = 2'b10; tick(4);
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0; tick(5);
        check_pde("clear wins over step", 8'd0, 1'b1, 1'b0);

        // ERROR_CLR on the same edge as an illegal transition
        {B, A} = 2'b01; tick(10);
        check_pde("illegal sets error", 8'd0, 1'b1, 1'b1);
        {B, A} = 2'b10; tick(4);
        ERROR_CLR = 1'b1; tick(1); ERROR_CLR = 1'b0; tick(5);
        check_pde("error set wins over clear", 8'd0, 1'b1, 1'b1);

        // reset in the middle of a window
        RESET = 1'b1; {B, A} = 2'b00; tick(2); RESET = 1'b0;
        {B, A} = 2'b01; cur_i = 0; tick(10);
        for (int i = 0; i < 37; i++) step(1'b1, 6);
        check_pde("position before reset", 8'd37, 1'b1, 1'b0);
        RESET = 1'b1; {B, A} = 2'b10; tick(1);
        check("outputs during reset",
              64'({pos_a, dir_a, err_a, spd_a, sv_a, spd_b, sv_b}), 64'd0);
        tick(1); RESET = 1'b0; tick(10);
        check_pde("no step after reset", 8'd0, 1'b0, 1'b0);
        {B, A} = 2'b00; tick(10);
        check_pde("first real step after reset", 8'd1, 1'b1, 1'b0);

        // speed windows
        RESET = 1'b1; {B, A} = 2'b00; cur_i = 3; tick(2);
        RESET = 1'b0;
        pulse_q = {};
        for (int i = 0; i < 60; i++) step(1'b1, 5);
        for (int i = 0; i < 20; i++) step(1'b1, 10);
        for (int i = 0; i < 20; i++) step(1'b0, 5);
        tick(3);
        check("pulse count", 64'(pulse_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < pulse_q.size(); i++) begin
            check($sformatf("pulse%0d", i),
                  64'({32'(pulse_q[i].edge_i), pulse_q[i].a, pulse_q[i].b}),
                  64'({32'(exp_edge[i]), exp_a[i], exp_b[i]}));
        end

        // randomized stimulus, checked by the model every cycle
        for (int it = 0; it < 2500; it++) begin
            int hold;
            hold = $urandom_range(1, 8);
            {B, A} = 2'($urandom_range(0, 3));
            CLEAR = ($urandom_range(0, 15) == 0);
            ERROR_CLR = ($urandom_range(0, 7) == 0);
            RESET = ($urandom_range(0, 199) == 0);
            tick(1);
            CLEAR = 1'b0; ERROR_CLR = 1'b0; RESET = 1'b0;
            if (hold > 1) tick(hold - 1);
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
